// File: rtl/hist_ctrl_if.sv
// Command, event, RAM and dump-stream signals of the histogram sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface hist_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic              cmd_ready;
    logic              ev_strobe;
    logic [ADDR_W-1:0] ev_bin;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport slave (
        input  cmd_valid, cmd, ev_strobe, ev_bin, mem_rdata, out_ready,
        output cmd_ready, mem_addr, mem_we, mem_wdata, out_valid, out_data, out_last
    );

    modport master (
        output cmd_valid, cmd, ev_strobe, ev_bin, mem_rdata, out_ready,
        input  cmd_ready, mem_addr, mem_we, mem_wdata, out_valid, out_data, out_last
    );
endinterface

// File: rtl/hist_ctrl.sv
// Histogram RAM sequencer: clear, read-modify-write accumulate, and dump.
// State | meaning: IDLE=0 wait cmd | CLEAR=1 zero RAM | RUN=2 accumulate | DRAIN=3 finish pending | DUMP=4 stream bins
module hist_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DROP_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    hist_ctrl_if.slave        io_bus,
    output logic [DROP_W-1:0] o_drop_cnt,
    output logic [2:0]        o_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DUMP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        D_ISSUE = 2'd0,
        D_LOAD  = 2'd1,
        D_HOLD  = 2'd2
    } dump_t;

    localparam logic [1:0]        CMD_STOP  = 2'b00;
    localparam logic [1:0]        CMD_CLEAR = 2'b01;
    localparam logic [1:0]        CMD_RUN   = 2'b10;
    localparam logic [1:0]        CMD_DUMP  = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] DATA_MAX  = {DATA_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

    state_t            r_state,     w_state_nxt;
    dump_t             r_dump,      w_dump_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic              r_buf_vld,   w_buf_vld_nxt;
    logic [ADDR_W-1:0] r_buf_bin,   w_buf_bin_nxt;
    logic              r_rmw_wr,    w_rmw_wr_nxt;
    logic [ADDR_W-1:0] r_rmw_bin,   w_rmw_bin_nxt;
    logic [DROP_W-1:0] r_drop_cnt,  w_drop_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [DATA_W-1:0] r_out_data,  w_out_data_nxt;
    logic              r_out_last,  w_out_last_nxt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_inc;
    logic              w_consume;
    logic              w_cmd_ready;
    logic              w_cmd_acc;

    assign w_inc       = (io_bus.mem_rdata == DATA_MAX) ? DATA_MAX : io_bus.mem_rdata + DATA_ONE;
    assign w_cmd_ready = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_cmd_acc   = io_bus.cmd_valid && w_cmd_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_dump_nxt      = r_dump;
        w_addr_nxt      = r_addr;
        w_buf_vld_nxt   = r_buf_vld;
        w_buf_bin_nxt   = r_buf_bin;
        w_rmw_wr_nxt    = 1'b0;
        w_rmw_bin_nxt   = r_rmw_bin;
        w_drop_nxt      = r_drop_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_mem_addr      = '0;
        w_mem_we        = 1'b0;
        w_mem_wdata     = '0;
        w_consume       = 1'b0;

        // RMW engine keeps running through DRAIN so buffered work is never lost
        if (r_state == S_RUN || r_state == S_DRAIN) begin
            if (r_rmw_wr) begin
                w_mem_addr  = r_rmw_bin;
                w_mem_we    = 1'b1;
                w_mem_wdata = w_inc;
            end else if (r_buf_vld) begin
                w_mem_addr    = r_buf_bin;
                w_consume     = 1'b1;
                w_rmw_wr_nxt  = 1'b1;
                w_rmw_bin_nxt = r_buf_bin;
                w_buf_vld_nxt = 1'b0;
            end
        end

        if (r_state == S_RUN && io_bus.ev_strobe) begin
            if (!r_buf_vld || w_consume) begin
                w_buf_vld_nxt = 1'b1;
                w_buf_bin_nxt = io_bus.ev_bin;
            end else if (r_drop_cnt != DROP_MAX) begin
                w_drop_nxt = r_drop_cnt + DROP_ONE;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    case (io_bus.cmd)
                        CMD_CLEAR: begin
                            w_state_nxt = S_CLEAR;
                            w_addr_nxt  = '0;
                            w_drop_nxt  = '0;
                        end
                        CMD_RUN:  w_state_nxt = S_RUN;
                        CMD_DUMP: begin
                            w_state_nxt = S_DUMP;
                            w_addr_nxt  = '0;
                            w_dump_nxt  = D_ISSUE;
                        end
                        default: ;
                    endcase
                end
            end
            S_CLEAR: begin
                w_mem_addr = r_addr;
                w_mem_we   = 1'b1;
                w_addr_nxt = r_addr + ADDR_ONE;
                if (r_addr == ADDR_MAX) w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (w_cmd_acc && io_bus.cmd == CMD_STOP) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_rmw_wr && !r_buf_vld) w_state_nxt = S_IDLE;
            end
            S_DUMP: begin
                case (r_dump)
                    D_ISSUE: begin
                        w_mem_addr = r_addr;
                        w_dump_nxt = D_LOAD;
                    end
                    D_LOAD: begin
                        w_out_data_nxt  = io_bus.mem_rdata;
                        w_out_valid_nxt = 1'b1;
                        w_out_last_nxt  = (r_addr == ADDR_MAX);
                        w_dump_nxt      = D_HOLD;
                    end
                    default: begin
                        w_mem_addr = r_addr;
                        if (io_bus.out_ready) begin
                            w_out_valid_nxt = 1'b0;
                            w_out_last_nxt  = 1'b0;
                            if (r_addr == ADDR_MAX) begin
                                w_state_nxt = S_IDLE;
                                w_addr_nxt  = '0;
                            end else begin
                                // overlap the next read with this handshake: 2 cycles per word
                                w_mem_addr = r_addr + ADDR_ONE;
                                w_addr_nxt = r_addr + ADDR_ONE;
                                w_dump_nxt = D_LOAD;
                            end
                        end
                    end
                endcase
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_dump      <= D_ISSUE;
            r_addr      <= '0;
            r_buf_vld   <= 1'b0;
            r_buf_bin   <= '0;
            r_rmw_wr    <= 1'b0;
            r_rmw_bin   <= '0;
            r_drop_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dump      <= w_dump_nxt;
            r_addr      <= w_addr_nxt;
            r_buf_vld   <= w_buf_vld_nxt;
            r_buf_bin   <= w_buf_bin_nxt;
            r_rmw_wr    <= w_rmw_wr_nxt;
            r_rmw_bin   <= w_rmw_bin_nxt;
            r_drop_cnt  <= w_drop_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    assign io_bus.cmd_ready = w_cmd_ready;
    assign io_bus.mem_addr  = w_mem_addr;
    assign io_bus.mem_we    = w_mem_we;
    assign io_bus.mem_wdata = w_mem_wdata;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_last  = r_out_last;
    assign o_drop_cnt       = r_drop_cnt;
    assign o_state          = r_state;
endmodule

// File: tb/tb_hist_ctrl.sv
// Bench for hist_ctrl: RAM model, event-acceptance reference model, table rows and directed sequences.
module tb_hist_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] drop_cnt;
    logic [2:0]  state;

    hist_ctrl_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    hist_ctrl #(.ADDR_W(7), .DATA_W(32), .DROP_W(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .io_bus     (bus),
        .o_drop_cnt (drop_cnt),
        .o_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [128];
    logic        pre_en;
    logic [6:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int          checks;
    int          errors;
    logic [31:0] exp_hist [128];
    logic [31:0] got [128];
    logic [15:0] exp_drop;
    int          tcyc;
    int          last_read;

    typedef struct {
        logic [7:0]  pat;
        logic [6:0]  bin;
        logic [31:0] cnt;
        logic [15:0] drop;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) exp_hist[i] = 32'd0;
        exp_drop = 16'd0;
    endtask

    // An event is taken only if every earlier event has started its read by now;
    // reads are spaced at least 2 cycles apart and come no earlier than the next cycle.
    task automatic drive(input logic s, input logic [6:0] b);
        @(negedge clk);
        bus.ev_strobe = s;
        bus.ev_bin    = b;
        if (s) begin
            if (last_read <= tcyc) begin
                last_read = (tcyc + 1 > last_read + 2) ? tcyc + 1 : last_read + 2;
                if (exp_hist[b] != 32'hFFFF_FFFF) exp_hist[b] = exp_hist[b] + 32'd1;
            end else if (exp_drop != 16'hFFFF) begin
                exp_drop = exp_drop + 16'd1;
            end
        end
        tcyc++;
    endtask

    task automatic do_cmd(input logic [1:0] c);
        @(negedge clk);
        bus.ev_strobe = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tcyc += 2;
    endtask

    task automatic start_run();
        do_cmd(2'b10);
        last_read = tcyc - 10;
    endtask

    task automatic do_clear(input logic timing);
        int cnt;
        logic ok;
        do_cmd(2'b01);
        if (timing) chk("clear_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        cnt = 0;
        ok  = 1'b1;
        while (state == 3'd1 && cnt < 400) begin
            if (!(bus.mem_we && bus.mem_addr == cnt[6:0] && bus.mem_wdata == 32'd0)) ok = 1'b0;
            cnt++;
            @(negedge clk);
        end
        if (timing) begin
            chk("clear_cycles", 32'(cnt), 32'd128);
            chk("clear_addr_seq", 32'(ok), 32'd1);
        end
        chk("clear_done_idle", 32'(state), 32'd0);
        model_clear();
    endtask

    task automatic wait_idle(input logic noisy);
        int cnt;
        cnt = 0;
        while (state != 3'd0 && cnt < 100) begin
            @(negedge clk);
            if (noisy) begin
                bus.ev_strobe = 1'($urandom_range(0, 1));
                bus.ev_bin    = 7'($urandom_range(0, 127));
            end
            cnt++;
        end
        bus.ev_strobe = 1'b0;
        chk("drain_to_idle", 32'(state), 32'd0);
    endtask

    task automatic dump_check(input int mode, input string tag);
        int          idx;
        int          cyc;
        int          ph;
        logic        stalled;
        logic        rdy;
        logic [31:0] held;
        do_cmd(2'b11);
        idx = 0; cyc = 0; ph = 0; stalled = 1'b0; held = 32'd0;
        while (idx < 128 && cyc < 2000) begin
            if (stalled) begin
                chk({tag, "_stall_data"}, bus.out_data, held);
                chk({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
            end
            rdy = (mode == 0) ? 1'b1 : (ph % 3 == 0);
            ph++;
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                got[idx] = bus.out_data;
                chk($sformatf("%s_word%0d", tag, idx), bus.out_data, exp_hist[idx]);
                chk($sformatf("%s_last%0d", tag, idx), 32'(bus.out_last), 32'(idx == 127));
                idx++;
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                held    = bus.out_data;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        tcyc += cyc;
        if (idx < 128) chk({tag, "_dump_timeout"}, 32'(idx), 32'd128);
        if (mode == 0) chk({tag, "_dump_cycles"}, 32'(cyc), 32'd257);
        chk({tag, "_dump_idle"}, 32'(state), 32'd0);
        chk({tag, "_dump_valid_low"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; tcyc = 0; last_read = -10;
        bus.cmd_valid = 1'b0; bus.cmd = 2'b00; bus.ev_strobe = 1'b0; bus.ev_bin = 7'd0;
        bus.out_ready = 1'b0;
        pre_en = 1'b0; pre_addr = 7'd0; pre_data = 32'd0;
        model_clear();

        vecs[0] = '{8'b0001_0101, 7'd5,   32'd3, 16'd0};
        vecs[1] = '{8'b0000_1111, 7'd6,   32'd3, 16'd1};
        vecs[2] = '{8'b1111_1111, 7'd0,   32'd5, 16'd3};
        vecs[3] = '{8'b0000_0011, 7'd127, 32'd2, 16'd0};
        vecs[4] = '{8'b0000_0001, 7'd64,  32'd1, 16'd0};
        vecs[5] = '{8'b0110_0110, 7'd33,  32'd4, 16'd0};
        vecs[6] = '{8'b0000_0111, 7'd12,  32'd2, 16'd1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state",     32'(state),         32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data,       32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_drop",      32'(drop_cnt),      32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        do_cmd(2'b00);
        chk("idle_stop_noop", 32'(state), 32'd0);

        do_clear(1'b1);
        dump_check(0, "clr");

        // single event latency: READ next cycle, WRITE the one after
        start_run();
        chk("run_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        drive(1'b1, 7'd17);
        drive(1'b0, 7'd0);
        chk("lat_read_we",   32'(bus.mem_we),   32'd0);
        chk("lat_read_addr", 32'(bus.mem_addr), 32'd17);
        drive(1'b0, 7'd0);
        chk("lat_wr_we",     32'(bus.mem_we),   32'd1);
        chk("lat_wr_addr",   32'(bus.mem_addr), 32'd17);
        chk("lat_wr_data",   bus.mem_wdata,     32'd1);
        do_cmd(2'b00);
        wait_idle(1'b0);

        // consecutive strobes to distinct bins
        do_clear(1'b0);
        start_run();
        for (int k = 1; k <= 4; k++) drive(1'b1, 7'(k));
        do_cmd(2'b00);
        wait_idle(1'b1);
        chk("burst_drop", 32'(drop_cnt), 32'd1);
        dump_check(0, "burst");
        chk("burst_bin1", got[1], 32'd1);
        chk("burst_bin2", got[2], 32'd1);
        chk("burst_bin3", got[3], 32'd0);
        chk("burst_bin4", got[4], 32'd1);
        chk("burst_total", got[1] + got[2] + got[3] + got[4] + 32'(drop_cnt), 32'd4);

        for (int i = 0; i < 7; i++) begin
            do_clear(1'b0);
            start_run();
            for (int k = 0; k < 8; k++) drive(vecs[i].pat[k], vecs[i].bin);
            do_cmd(2'b00);
            wait_idle(1'b0);
            chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].drop));
            dump_check(0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_cnt", i), got[vecs[i].bin], vecs[i].cnt);
        end

        // counter saturation near the top of the range
        do_clear(1'b0);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = 7'd9; pre_data = 32'hFFFF_FFFD;
        @(negedge clk);
        pre_en = 1'b0;
        tcyc += 2;
        exp_hist[9] = 32'hFFFF_FFFD;
        start_run();
        for (int k = 0; k < 8; k++) drive(k % 2 == 0, 7'd9);
        do_cmd(2'b00);
        wait_idle(1'b0);
        dump_check(0, "sat");
        chk("sat_bin9", got[9], 32'hFFFF_FFFF);

        // random bursty traffic over a few bins, stalled dump
        do_clear(1'b0);
        start_run();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 99) < 45,
                  ($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom_range(0, 5)));
        end
        do_cmd(2'b00);
        wait_idle(1'b1);
        chk("rand_drop", 32'(drop_cnt), 32'(exp_drop));
        dump_check(1, "rand");

        // reset in the middle of a clear
        do_cmd(2'b01);
        for (int k = 0; k < 200 && !(bus.mem_we && bus.mem_addr == 7'd40); k++) @(negedge clk);
        chk("mid_clear_addr", 32'(bus.mem_addr), 32'd40);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_we",        32'(bus.mem_we),    32'd0);
        chk("mid_rst_state",     32'(state),         32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_we",       32'(bus.mem_we),    32'd0);
        chk("post_rst_state",    32'(state),         32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
